// File: rtl/instr_fetch_unit.sv
// Fetch unit: accepts PCs, issues one imem read at a time, buffers {pc, instr} toward IF/ID, handles flush.
// Optional macro IFU_BYPASS_EN forwards a response straight to id_* when the buffer is empty.
module instr_fetch_unit #(
  parameter int ADDR_W     = 64,
  parameter int INSTR_W    = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  pc_in,
  input  logic               pc_valid,
  output logic               stall,
  input  logic               flush,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               id_valid,
  output logic [INSTR_W-1:0] id_instr,
  output logic [ADDR_W-1:0]  id_pc,
  input  logic               id_ready
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, WAIT_GNT, WAIT_RESP, DROP} state_t;

  state_t             state_q, state_d;
  logic               imem_req_q, imem_req_d;
  logic [ADDR_W-1:0]  imem_addr_q, imem_addr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic               id_valid_q, id_valid_d;
  logic [ADDR_W-1:0]  id_pc_q, id_pc_d;
  logic [INSTR_W-1:0] id_instr_q, id_instr_d;
  logic [ADDR_W-1:0]  fifo_pc    [FIFO_DEPTH];
  logic [INSTR_W-1:0] fifo_instr [FIFO_DEPTH];
  logic               push, pop, fifo_full, byp_vld, byp_take, head_is_new;

  assign fifo_full = (count_q == CNT_W'(FIFO_DEPTH));
  assign stall     = (state_q != IDLE) | fifo_full;
  assign imem_req  = imem_req_q;
  assign imem_addr = imem_addr_q;

`ifdef IFU_BYPASS_EN
  assign byp_vld = (count_q == '0) & (state_q == WAIT_RESP) & imem_rvalid & ~flush;
`else
  assign byp_vld = 1'b0;
`endif
  assign byp_take = byp_vld & id_ready;
  assign id_valid = id_valid_q | byp_vld;
  assign id_pc    = byp_vld ? imem_addr_q : id_pc_q;
  assign id_instr = byp_vld ? imem_rdata  : id_instr_q;

  always_comb begin
    state_d     = state_q;
    imem_req_d  = imem_req_q;
    imem_addr_d = imem_addr_q;
    count_d     = count_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    push        = 1'b0;
    pop         = 1'b0;
    if (flush) begin
      // A response still owed by memory must be swallowed before the next request.
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      imem_req_d = 1'b0;
      state_d    = ((state_q == WAIT_RESP || state_q == DROP) && !imem_rvalid) ? DROP : IDLE;
    end else begin
      pop = id_valid_q & id_ready;
      unique case (state_q)
        IDLE: begin
          if (pc_valid && !fifo_full) begin
            imem_addr_d = pc_in;
            imem_req_d  = 1'b1;
            state_d     = WAIT_GNT;
          end
        end
        WAIT_GNT: begin
          if (imem_gnt) begin
            imem_req_d = 1'b0;
            state_d    = WAIT_RESP;
          end
        end
        WAIT_RESP: begin
          if (imem_rvalid) begin
            push    = ~byp_take;
            state_d = IDLE;
          end
        end
        DROP: begin
          if (imem_rvalid) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
      rd_ptr_d = rd_ptr_q + PTR_W'(pop);
      wr_ptr_d = wr_ptr_q + PTR_W'(push);
      count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Registered head view; holds the last shown entry once the buffer drains.
  always_comb begin
    head_is_new = push && (wr_ptr_q == rd_ptr_d);
    id_valid_d  = (count_d != '0);
    id_pc_d     = id_pc_q;
    id_instr_d  = id_instr_q;
    if (count_d != '0) begin
      id_pc_d    = head_is_new ? imem_addr_q : fifo_pc[rd_ptr_d];
      id_instr_d = head_is_new ? imem_rdata  : fifo_instr[rd_ptr_d];
    end else if (byp_take) begin
      id_pc_d    = imem_addr_q;
      id_instr_d = imem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      imem_req_q  <= 1'b0;
      imem_addr_q <= '0;
      count_q     <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      id_valid_q  <= 1'b0;
      id_pc_q     <= '0;
      id_instr_q  <= '0;
    end else begin
      state_q     <= state_d;
      imem_req_q  <= imem_req_d;
      imem_addr_q <= imem_addr_d;
      count_q     <= count_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      id_valid_q  <= id_valid_d;
      id_pc_q     <= id_pc_d;
      id_instr_q  <= id_instr_d;
      if (push) begin
        fifo_pc[wr_ptr_q]    <= imem_addr_q;
        fifo_instr[wr_ptr_q] <= imem_rdata;
      end
    end
  end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: vector table, directed corner sequences, and random traffic vs a queue-based model.
module tb_instr_fetch_unit;
`ifdef IFU_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset, pc_valid, flush, imem_gnt, imem_rvalid, id_ready;
  logic [63:0] pc_in;
  logic [31:0] imem_rdata;
  logic        stall, imem_req, id_valid;
  logic [63:0] imem_addr, id_pc;
  logic [31:0] id_instr;

  always #5 clk = ~clk;

  instr_fetch_unit #(.ADDR_W(64), .INSTR_W(32), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .pc_in(pc_in), .pc_valid(pc_valid), .stall(stall),
    .flush(flush), .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .id_valid(id_valid),
    .id_instr(id_instr), .id_pc(id_pc), .id_ready(id_ready)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: fetch phase (0 none, 1 awaiting grant, 2 awaiting data, 3 discarding) plus a queue.
  typedef struct { logic [63:0] pc; logic [31:0] instr; } ent_t;
  ent_t        m_q[$];
  int          m_phase;
  logic [63:0] m_addr, m_last_pc;
  logic [31:0] m_last_instr;

  task automatic model_reset();
    m_q.delete();
    m_phase = 0;
    m_addr = '0;
    m_last_pc = '0;
    m_last_instr = '0;
  endtask

  logic        o_stall, o_req, o_idv;
  logic [63:0] o_addr, o_pc;
  logic [31:0] o_instr;

  task automatic step(input logic rst, input logic pcv, input logic [63:0] pc, input logic gnt,
                      input logic rv, input logic [31:0] rd, input logic fl, input logic rdy);
    bit e_stall, byp, shown;
    ent_t e;
    reset = rst; pc_valid = pcv; pc_in = pc; imem_gnt = gnt;
    imem_rvalid = rv; imem_rdata = rd; flush = fl; id_ready = rdy;
    #4;
    o_stall = stall; o_req = imem_req; o_addr = imem_addr;
    o_idv = id_valid; o_pc = id_pc; o_instr = id_instr;
    e_stall = (m_phase != 0) || (m_q.size() == DEPTH);
    byp = BYP && (m_q.size() == 0) && (m_phase == 2) && rv && !fl;
    shown = (m_q.size() > 0) || byp;
    if (m_q.size() > 0) e = m_q[0];
    else if (byp) begin e.pc = m_addr; e.instr = rd; end
    else begin e.pc = m_last_pc; e.instr = m_last_instr; end
    chk("m_stall", o_stall, 64'(e_stall));
    chk("m_req", o_req, 64'(m_phase == 1));
    chk("m_addr", o_addr, m_addr);
    chk("m_idv", o_idv, 64'(shown));
    chk("m_pc", o_pc, e.pc);
    chk("m_instr", o_instr, 64'(e.instr));
    @(posedge clk);
    if (rst) model_reset();
    else begin
      if (shown) begin m_last_pc = e.pc; m_last_instr = e.instr; end
      if (fl) begin
        m_q.delete();
        m_phase = ((m_phase >= 2) && !rv) ? 3 : 0;
      end else begin
        if (m_q.size() > 0 && rdy) void'(m_q.pop_front());
        case (m_phase)
          0: if (pcv && !e_stall) begin m_addr = pc; m_phase = 1; end
          1: if (gnt) m_phase = 2;
          2: if (rv) begin
               if (!(byp && rdy)) begin e.pc = m_addr; e.instr = rd; m_q.push_back(e); end
               m_phase = 0;
             end
          default: if (rv) m_phase = 0;
        endcase
      end
    end
    #1;
  endtask

  task automatic idle(input logic rdy);
    step(0, 0, 64'h0, 0, 0, 32'h0, 0, rdy);
  endtask

  typedef struct {
    logic pcv; logic [63:0] pc; logic gnt; logic rv; logic [31:0] rd; logic rdy;
    logic e_stall; logic e_req; logic e_idv; logic [63:0] e_pc; logic [31:0] e_instr;
  } vec_t;
  vec_t vt[$];

  function automatic vec_t mkv(logic pcv, logic [63:0] pc, logic gnt, logic rv, logic [31:0] rd,
                               logic rdy, logic es, logic er, logic ev, logic [63:0] ep, logic [31:0] ei);
    vec_t v;
    v.pcv = pcv; v.pc = pc; v.gnt = gnt; v.rv = rv; v.rd = rd; v.rdy = rdy;
    v.e_stall = es; v.e_req = er; v.e_idv = ev; v.e_pc = ep; v.e_instr = ei;
    return v;
  endfunction

  initial begin
    logic [31:0] b0;
    b0 = 32'hB000_0000;
    // Single fetch with immediate grant/data, then fill the buffer with id_ready low.
    vt.push_back(mkv(1, 64'h0, 0, 0, 32'h0,          1, 0, 0, 0,    64'h0, 32'h0));
    vt.push_back(mkv(0, 64'h0, 1, 0, 32'h0,          1, 1, 1, 0,    64'h0, 32'h0));
    vt.push_back(mkv(0, 64'h0, 0, 1, 32'hA000_0000,  1, 1, 0, BYP,  64'h0, 32'hA000_0000));
    vt.push_back(mkv(0, 64'h0, 0, 0, 32'h0,          1, 0, 0, !BYP, 64'h0, 32'hA000_0000));
    vt.push_back(mkv(0, 64'h0, 0, 0, 32'h0,          1, 0, 0, 0,    64'h0, 32'h0));
    for (int k = 0; k < 4; k++) begin
      vt.push_back(mkv(1, 64'(4 * k), 0, 0, 32'h0,   0, 0, 0, k > 0,         64'h0, b0));
      vt.push_back(mkv(0, 64'h0, 1, 0, 32'h0,        0, 1, 1, k > 0,         64'h0, b0));
      vt.push_back(mkv(0, 64'h0, 0, 1, b0 + 32'(k),  0, 1, 0, (k > 0) | BYP, 64'h0, b0));
    end
    vt.push_back(mkv(1, 64'h10, 0, 0, 32'h0,         0, 1, 0, 1, 64'h0, b0));
    vt.push_back(mkv(1, 64'h10, 0, 0, 32'h0,         0, 1, 0, 1, 64'h0, b0));
    vt.push_back(mkv(1, 64'h10, 0, 0, 32'h0,         1, 1, 0, 1, 64'h0, b0));
    vt.push_back(mkv(1, 64'h10, 0, 0, 32'h0,         0, 0, 0, 1, 64'h4, b0 + 32'd1));
    vt.push_back(mkv(0, 64'h0, 1, 0, 32'h0,          0, 1, 1, 1, 64'h4, b0 + 32'd1));
    vt.push_back(mkv(0, 64'h0, 0, 1, b0 + 32'd4,     0, 1, 0, 1, 64'h4, b0 + 32'd1));
    vt.push_back(mkv(0, 64'h0, 0, 0, 32'h0,          0, 1, 0, 1, 64'h4, b0 + 32'd1));

    reset = 1; pc_valid = 0; pc_in = '0; flush = 0; imem_gnt = 0;
    imem_rvalid = 0; imem_rdata = '0; id_ready = 0;
    model_reset();
    @(posedge clk); #1;
    step(1, 0, 64'h0, 0, 0, 32'h0, 0, 0);
    idle(0);
    chk("rst_stall", o_stall, 0);
    chk("rst_req", o_req, 0);
    chk("rst_idv", o_idv, 0);
    chk("rst_pc", o_pc, 0);
    chk("rst_instr", o_instr, 0);

    foreach (vt[i]) begin
      step(0, vt[i].pcv, vt[i].pc, vt[i].gnt, vt[i].rv, vt[i].rd, 0, vt[i].rdy);
      chk($sformatf("vec%0d_stall", i), o_stall, 64'(vt[i].e_stall));
      chk($sformatf("vec%0d_req", i), o_req, 64'(vt[i].e_req));
      chk($sformatf("vec%0d_idv", i), o_idv, 64'(vt[i].e_idv));
      if (vt[i].e_idv) begin
        chk($sformatf("vec%0d_pc", i), o_pc, vt[i].e_pc);
        chk($sformatf("vec%0d_instr", i), o_instr, 64'(vt[i].e_instr));
      end
    end

    // Flush while waiting for grant, then a clean fetch of the redirect target.
    step(1, 0, 64'h0, 0, 0, 32'h0, 0, 0);
    step(0, 1, 64'h40, 0, 0, 32'h0, 0, 1);
    step(0, 0, 64'h0, 0, 0, 32'h0, 1, 1);
    chk("fgnt_req_before", o_req, 1);
    idle(1);
    chk("fgnt_req_after", o_req, 0);
    chk("fgnt_idv", o_idv, 0);
    step(0, 1, 64'h100, 0, 0, 32'h0, 0, 1);
    step(0, 0, 64'h0, 1, 0, 32'h0, 0, 1);
    step(0, 0, 64'h0, 0, 1, 32'h1234_5678, 0, 1);
    chk("lat_rv_cycle_idv", o_idv, 64'(BYP));
    idle(1);
    chk("lat_next_idv", o_idv, 64'(!BYP));
    chk("redir_pc", o_pc, 64'h100);
    chk("redir_instr", o_instr, 64'h1234_5678);

    // Flush while waiting for data; late response must vanish.
    step(0, 1, 64'h200, 0, 0, 32'h0, 0, 1);
    step(0, 0, 64'h0, 1, 0, 32'h0, 0, 1);
    step(0, 0, 64'h0, 0, 0, 32'h0, 1, 1);
    idle(1);
    chk("drop_stall", o_stall, 1);
    step(0, 0, 64'h0, 0, 1, 32'hDEAD_BEEF, 0, 1);
    chk("drop_rv_idv", o_idv, 0);
    idle(1);
    chk("drop_done_stall", o_stall, 0);
    chk("drop_idv", o_idv, 0);
    chk("drop_not_shown", 64'(o_instr == 32'hDEAD_BEEF), 0);

    // Reset mid-response, stray data afterwards.
    step(0, 1, 64'h300, 0, 0, 32'h0, 0, 1);
    step(0, 0, 64'h0, 1, 0, 32'h0, 0, 1);
    step(1, 0, 64'h0, 0, 0, 32'h0, 0, 1);
    step(0, 0, 64'h0, 0, 1, 32'hCAFE_F00D, 0, 1);
    idle(1);
    chk("stray_idv", o_idv, 0);
    chk("stray_stall", o_stall, 0);

    for (int c = 0; c < 1500; c++) begin
      step($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0,
           {$urandom, $urandom}, $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
           $urandom, $urandom_range(0, 19) == 0, $urandom_range(0, 2) != 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
